multi_cycle_sequencer: RTL and testbench

MULTI_CYCLE_SEQUENCER -- requirements
Module: multi_cycle_sequencer

---
 rtl/multi_cycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_sequencer.sv
// multi_cycle_sequencer
//
// This block expands CALL, RET and RTI into a two-opcode pair for the control
// unit. It also injects a two-opcode interrupt entry sequence (11110, 11111)
// when an interrupt is pending. While a pair is in flight, the PC and the
// fetch/decode register are held. This keeps the instruction in decode
// available, so it can be presented again after the sequence.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   inOpCode   [4:0] opcode currently in decode
//   interrupt  interrupt request (a single-cycle pulse is enough)
//   stall      hazard stall; freezes sequencing and issues a bubble
//   outOpCode  [4:0] opcode presented to the control unit
//   pcHold     1 = PC and fetch/decode register must not advance
//   intAck     1 in the cycle 11111 is issued
//   busy       1 while a second part is outstanding (state != IDLE)
module multi_cycle_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] inOpCode,
  input  logic       interrupt,
  input  logic       stall,
  output logic [4:0] outOpCode,
  output logic       pcHold,
  output logic       intAck,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALL2 = 3'd1,
    RET2  = 3'd2,
    RTI2  = 3'd3,
    INT1  = 3'd4,
    INT2  = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_CALL1 = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET1  = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI1  = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT1  = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;

  state_t     state_q, state_d;
  logic       intPending_q, intPending_d;
  logic [4:0] outOpCode_d;
  logic       pcHold_d;
  logic       intAck_d;

  // Next state and outputs are decoded together. The outputs are combinational
  // so that the control unit sees the opcode in the same cycle as decode.
  always_comb begin
    state_d     = state_q;
    outOpCode_d = OP_NOP;
    pcHold_d    = 1'b0;
    intAck_d    = 1'b0;
    if (rst) begin
      state_d = IDLE;
    end else if (stall) begin
      // Bubble to the control unit. Holding the PC keeps the pair intact.
      pcHold_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (intPending_q) begin
            // The interrupt beats decode. The held opcode is replayed later.
            outOpCode_d = OP_INT1;
            pcHold_d    = 1'b1;
            state_d     = INT2;
          end else begin
            unique case (inOpCode)
              OP_CALL1: begin
                outOpCode_d = OP_CALL1;
                pcHold_d    = 1'b1;
                state_d     = CALL2;
              end
              OP_RET1: begin
                outOpCode_d = OP_RET1;
                pcHold_d    = 1'b1;
                state_d     = RET2;
              end
              OP_RTI1: begin
                outOpCode_d = OP_RTI1;
                pcHold_d    = 1'b1;
                state_d     = RTI2;
              end
              // Second-part and interrupt opcodes are never legal from fetch.
              OP_CALL2, OP_RET2, OP_RTI2, OP_INT1, OP_INT2: begin
                outOpCode_d = OP_NOP;
              end
              default: begin
                outOpCode_d = inOpCode;
              end
            endcase
          end
        end
        CALL2: begin
          outOpCode_d = OP_CALL2;
          state_d     = IDLE;
        end
        RET2: begin
          outOpCode_d = OP_RET2;
          state_d     = IDLE;
        end
        RTI2: begin
          outOpCode_d = OP_RTI2;
          state_d     = IDLE;
        end
        INT2: begin
          outOpCode_d = OP_INT2;
          intAck_d    = 1'b1;
          state_d     = IDLE;
        end
        // INT1 is reserved, and the two spare encodings are unused. Each of
        // them issues a bubble and returns to IDLE.
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // A new request always wins over the clear at the end of INT2.
  always_comb begin
    intPending_d = intPending_q;
    if (rst) begin
      intPending_d = 1'b0;
    end else if (interrupt) begin
      intPending_d = 1'b1;
    end else if (!stall && state_q == INT2) begin
      intPending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    intPending_q <= intPending_d;
  end

  assign outOpCode = outOpCode_d;
  assign pcHold    = pcHold_d;
  assign intAck    = intAck_d;
  assign busy      = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Testbench for multi_cycle_sequencer.
// The reference model is an "issue queue": it holds at most one outstanding
// second-part opcode plus a pending-interrupt flag. There is no state encoding.
module tb_multi_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] inOpCode;
  logic       interrupt;
  logic       stall;
  logic [4:0] outOpCode;
  logic       pcHold;
  logic       intAck;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit         m_has2;   // a second-part opcode is owed
  logic [4:0] m_op2;    // the owed opcode
  bit         m_pend;   // interrupt waiting to be served

  always #5 clk = ~clk;

  multi_cycle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .inOpCode  (inOpCode),
    .interrupt (interrupt),
    .stall     (stall),
    .outOpCode (outOpCode),
    .pcHold    (pcHold),
    .intAck    (intAck),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the inputs just after a rising edge, then let the logic settle.
  task automatic drive(input logic r, input logic [4:0] op, input logic irq, input logic st);
    rst       = r;
    inOpCode  = op;
    interrupt = irq;
    stall     = st;
    #1;
  endtask

  // These are the expected outputs for the current inputs, from the model rules.
  task automatic check_model(input string tag);
    logic [4:0] e_op;
    logic       e_hold, e_ack, e_busy;
    e_op = 5'b0; e_hold = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
    if (!rst) begin
      e_busy = m_has2;
      if (stall) begin
        e_hold = 1'b1;
      end else if (m_has2) begin
        e_op  = m_op2;
        e_ack = (m_op2 == 5'b11111);
      end else if (m_pend) begin
        e_op   = 5'b11110;
        e_hold = 1'b1;
      end else if (inOpCode == 5'b11000 || inOpCode == 5'b11010 || inOpCode == 5'b11100) begin
        e_op   = inOpCode;
        e_hold = 1'b1;
      end else if (inOpCode >= 5'b11000) begin
        e_op = 5'b0;
      end else begin
        e_op = inOpCode;
      end
    end
    chk({tag, ".op"},   outOpCode,       e_op);
    chk({tag, ".hold"}, {4'b0, pcHold},  {4'b0, e_hold});
    chk({tag, ".ack"},  {4'b0, intAck},  {4'b0, e_ack});
    chk({tag, ".busy"}, {4'b0, busy},    {4'b0, e_busy});
  endtask

  // Compare the outputs against fixed values that were worked out by hand.
  task automatic expect_c(input string tag, input logic [4:0] op, input logic h,
                          input logic a, input logic b);
    chk({tag, ".op"},   outOpCode,      op);
    chk({tag, ".hold"}, {4'b0, pcHold}, {4'b0, h});
    chk({tag, ".ack"},  {4'b0, intAck}, {4'b0, a});
    chk({tag, ".busy"}, {4'b0, busy},   {4'b0, b});
  endtask

  // Advance one clock and move the model forward using the inputs sampled at that edge.
  task automatic advance();
    bit clr;
    @(posedge clk);
    clr = 1'b0;
    if (rst) begin
      m_has2 = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (!stall) begin
        if (m_has2) begin
          clr    = (m_op2 == 5'b11111);
          m_has2 = 1'b0;
        end else if (m_pend) begin
          m_has2 = 1'b1;
          m_op2  = 5'b11111;
        end else if (inOpCode == 5'b11000 || inOpCode == 5'b11010 || inOpCode == 5'b11100) begin
          m_has2 = 1'b1;
          m_op2  = inOpCode + 5'd1;
        end
      end
      if (interrupt)  m_pend = 1'b1;
      else if (clr)   m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] op,
                      input logic irq, input logic st);
    drive(r, op, irq, st);
    check_model(tag);
  endtask

  initial begin
    int n11001;
    m_has2 = 1'b0; m_op2 = 5'b0; m_pend = 1'b0;
    rst = 1'b1; inOpCode = 5'b0; interrupt = 1'b0; stall = 1'b0;
    @(posedge clk); #1;

    // Reset state, with the other inputs active
    step("rst", 1'b1, 5'b11000, 1'b1, 1'b0);
    expect_c("rst_c", 5'b00000, 1'b0, 1'b0, 1'b0);
    advance();

    // CALL pair
    step("call1", 1'b0, 5'b11000, 1'b0, 1'b0); expect_c("call1_c", 5'b11000, 1'b1, 1'b0, 1'b0); advance();
    step("call2", 1'b0, 5'b11000, 1'b0, 1'b0); expect_c("call2_c", 5'b11001, 1'b0, 1'b0, 1'b1); advance();

    // An interrupt pulse during an ordinary instruction
    step("irq0", 1'b0, 5'b01001, 1'b1, 1'b0); expect_c("irq0_c", 5'b01001, 1'b0, 1'b0, 1'b0); advance();
    step("irq1", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("irq1_c", 5'b11110, 1'b1, 1'b0, 1'b0); advance();
    step("irq2", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("irq2_c", 5'b11111, 1'b0, 1'b1, 1'b1); advance();
    step("irq3", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("irq3_c", 5'b01001, 1'b0, 1'b0, 1'b0); advance();

    // RTI with three stalls in the second part
    step("rti1", 1'b0, 5'b11100, 1'b0, 1'b0); expect_c("rti1_c", 5'b11100, 1'b1, 1'b0, 1'b0); advance();
    for (int i = 0; i < 3; i++) begin
      step("rtis", 1'b0, 5'b11100, 1'b0, 1'b1); expect_c("rtis_c", 5'b00000, 1'b1, 1'b0, 1'b1); advance();
    end
    step("rti2", 1'b0, 5'b11100, 1'b0, 1'b0); expect_c("rti2_c", 5'b11101, 1'b0, 1'b0, 1'b1); advance();

    // An interrupt during RET2 does not pre-empt it
    step("ret1", 1'b0, 5'b11010, 1'b0, 1'b0); expect_c("ret1_c", 5'b11010, 1'b1, 1'b0, 1'b0); advance();
    step("ret2", 1'b0, 5'b01001, 1'b1, 1'b0); expect_c("ret2_c", 5'b11011, 1'b0, 1'b0, 1'b1); advance();
    step("rint1", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("rint1_c", 5'b11110, 1'b1, 1'b0, 1'b0); advance();
    step("rint2", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("rint2_c", 5'b11111, 1'b0, 1'b1, 1'b1); advance();
    step("rint3", 1'b0, 5'b01001, 1'b0, 1'b0); expect_c("rint3_c", 5'b01001, 1'b0, 1'b0, 1'b0); advance();

    // An illegal opcode from fetch
    step("ill", 1'b0, 5'b11011, 1'b0, 1'b0); expect_c("ill_c", 5'b00000, 1'b0, 1'b0, 1'b0); advance();
    step("ill_idle", 1'b0, 5'b00100, 1'b0, 1'b0); expect_c("ill_idle_c", 5'b00100, 1'b0, 1'b0, 1'b0); advance();

    // Reset in CALL2 abandons the second part
    step("rc1", 1'b0, 5'b11000, 1'b0, 1'b0); expect_c("rc1_c", 5'b11000, 1'b1, 1'b0, 1'b0); advance();
    step("rc_rst", 1'b1, 5'b11000, 1'b0, 1'b0); expect_c("rc_rst_c", 5'b00000, 1'b0, 1'b0, 1'b0); advance();
    n11001 = 0;
    for (int i = 0; i < 3; i++) begin
      step("rc_after", 1'b0, 5'b00100, 1'b0, 1'b0);
      expect_c("rc_after_c", 5'b00100, 1'b0, 1'b0, 1'b0);
      if (outOpCode == 5'b11001) n11001++;
      advance();
    end
    chk("rc_no_11001", n11001[4:0], 5'd0);

    // Randomized traffic, biased toward the multi-cycle opcodes
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 2) == 0) ? {2'b11, 3'($urandom_range(0, 7))} : 5'($urandom);
      step("rand", ($urandom_range(0, 60) == 0), op,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
